// File: rtl/alu.sv
// alu: 32-bit RV32I-style ALU with a combinational result and a registered result/flag stage
// Ports:
//   clk, rst                         core clock; synchronous active-high reset
//   operand_a, operand_b, alu_op     operands and operation select (b[4:0] = shift amount)
//   in_valid                         qualifies the inputs for the registered stage
//   result                           zero-latency combinational result
//   result_q, zero_q, neg_q          registered result and zero/negative flags
//   out_valid                        registered in_valid
package common;
  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10
  } alu_op_t;
endpackage

module alu
  import common::*;
#(
  parameter logic [31:0] NOP_VALUE = 32'h000E2202
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  alu_op_t     alu_op,
  input  logic        in_valid,
  output logic [31:0] result,
  output logic [31:0] result_q,
  output logic        zero_q,
  output logic        neg_q,
  output logic        out_valid
);
  logic [4:0]  w_shamt;
  logic [31:0] w_result;
  logic [31:0] r_result;
  logic        r_zero;
  logic        r_neg;
  logic        r_valid;

  assign w_shamt = operand_b[4:0];

  // unused encodings fall into default so result is never X for known inputs
  always_comb begin
    case (alu_op)
      ALU_ADD:  w_result = operand_a + operand_b;
      ALU_SUB:  w_result = operand_a - operand_b;
      ALU_AND:  w_result = operand_a & operand_b;
      ALU_OR:   w_result = operand_a | operand_b;
      ALU_XOR:  w_result = operand_a ^ operand_b;
      ALU_SLL:  w_result = operand_a << w_shamt;
      ALU_SRL:  w_result = operand_a >> w_shamt;
      ALU_SRA:  w_result = $unsigned($signed(operand_a) >>> w_shamt);
      ALU_SLT:  w_result = {31'd0, $signed(operand_a) < $signed(operand_b)};
      ALU_SLTU: w_result = {31'd0, operand_a < operand_b};
      default:  w_result = NOP_VALUE;
    endcase
  end

  // without in_valid only out_valid drops; the data and flags keep their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_result <= w_result;
        r_zero   <= w_result == '0;
        r_neg    <= w_result[31];
      end
    end
  end

  assign result    = w_result;
  assign result_q  = r_result;
  assign zero_q    = r_zero;
  assign neg_q     = r_neg;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_alu.sv
// tb_alu: self-checking bench for alu with a behavioural model and directed vectors
module tb_alu;
  import common::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  alu_op_t     alu_op = ALU_NOP;
  logic        in_valid = 1'b0;
  logic [31:0] result, result_q;
  logic        zero_q, neg_q, out_valid;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] m_result_q = '0;
  logic        m_zero = 1'b0, m_neg = 1'b0, m_valid = 1'b0;

  alu dut (
    .clk(clk), .rst(rst), .operand_a(operand_a), .operand_b(operand_b),
    .alu_op(alu_op), .in_valid(in_valid), .result(result), .result_q(result_q),
    .zero_q(zero_q), .neg_q(neg_q), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] ones = '1;
    int          s = int'(b % 32);
    int          sa = a;
    int          sb = b;
    logic [32:0] sum = {1'b0, a} + {1'b0, b};
    case (op)
      4'd1:    return sum[31:0];
      4'd2:    return a + (~b + 32'd1);
      4'd3:    return a & b;
      4'd4:    return a | b;
      4'd5:    return a ^ b;
      4'd6:    return a * (32'd1 << s);
      4'd7:    return a / (32'd1 << s);
      4'd8:    return (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd9:    return sa < sb ? 32'd1 : 32'd0;
      4'd10:   return a < b ? 32'd1 : 32'd0;
      default: return 32'h000E2202;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_result_q <= '0; m_zero <= 1'b0; m_neg <= 1'b0; m_valid <= 1'b0;
    end else begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_result_q <= ref_alu(operand_a, operand_b, alu_op);
        m_zero <= ref_alu(operand_a, operand_b, alu_op) == 32'd0;
        m_neg <= ref_alu(operand_a, operand_b, alu_op) >= 32'h80000000;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_result", result, ref_alu(operand_a, operand_b, alu_op));
    chk("model_result_q", result_q, m_result_q);
    chk("model_zero_q", {31'd0, zero_q}, {31'd0, m_zero});
    chk("model_neg_q", {31'd0, neg_q}, {31'd0, m_neg});
    chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic vec(string name, alu_op_t op, logic [31:0] a, logic [31:0] b, logic [31:0] exp);
    step();
    alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
    @(negedge clk);
    chk(name, result, exp);
  endtask

  initial begin
    repeat (2) step();
    @(negedge clk);
    chk("rst_result_q", result_q, 32'd0);
    chk("rst_zero_q", {31'd0, zero_q}, 32'd0);
    chk("rst_neg_q", {31'd0, neg_q}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    vec("add_wrap", ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'h00000000);
    vec("sub_wrap", ALU_SUB, 32'd0, 32'd1, 32'hFFFFFFFF);
    vec("and", ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    vec("or", ALU_OR, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001);
    vec("xor", ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
    vec("sll_1", ALU_SLL, 32'h80000000, 32'h21, 32'h00000000);
    vec("srl_1", ALU_SRL, 32'h80000000, 32'h21, 32'h40000000);
    vec("sra_1", ALU_SRA, 32'h80000000, 32'h21, 32'hC0000000);
    vec("sll_0", ALU_SLL, 32'h80000000, 32'h0, 32'h80000000);
    vec("srl_0", ALU_SRL, 32'h80000000, 32'h0, 32'h80000000);
    vec("sra_0", ALU_SRA, 32'h80000000, 32'h0, 32'h80000000);
    vec("sll_4", ALU_SLL, 32'h0000_0013, 32'hFFFF_FFE4, 32'h0000_0130);
    vec("sra_31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    vec("slt_neg", ALU_SLT, 32'h80000000, 32'd1, 32'd1);
    vec("sltu_neg", ALU_SLTU, 32'h80000000, 32'd1, 32'd0);
    vec("slt_zero", ALU_SLT, 32'h80000000, 32'd0, 32'd1);
    vec("sltu_zero", ALU_SLTU, 32'h80000000, 32'd0, 32'd0);
    vec("slt_eq", ALU_SLT, 32'd5, 32'd5, 32'd0);
    vec("sltu_eq", ALU_SLTU, 32'd5, 32'd5, 32'd0);
    vec("nop", ALU_NOP, 32'h1234_5678, 32'h9ABC_DEF0, 32'h000E2202);
    vec("undef_op", alu_op_t'(4'd13), 32'h1, 32'h2, 32'h000E2202);
    vec("sub_eq", ALU_SUB, 32'd7, 32'd7, 32'd0);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("sub_result_q", result_q, 32'd0);
    chk("sub_zero_q", {31'd0, zero_q}, 32'd1);
    chk("sub_out_valid", {31'd0, out_valid}, 32'd1);
    vec("add_neg", ALU_ADD, 32'hFFFF_FFF0, 32'd3, 32'hFFFF_FFF3);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("neg_result_q", result_q, 32'hFFFF_FFF3);
    chk("neg_neg_q", {31'd0, neg_q}, 32'd1);
    chk("neg_zero_q", {31'd0, zero_q}, 32'd0);
    step();
    @(negedge clk);
    chk("hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold_result_q", result_q, 32'hFFFF_FFF3);
    vec("rst_with_valid", ALU_ADD, 32'd1, 32'd2, 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstv_result_q", result_q, 32'd0);
    chk("rstv_neg_q", {31'd0, neg_q}, 32'd0);
    chk("rstv_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      step();
      operand_a = $urandom;
      operand_b = ($urandom_range(0, 3) == 0) ? operand_a : $urandom;
      alu_op = alu_op_t'($urandom_range(0, 15));
      in_valid = $urandom_range(0, 1) == 1;
      rst = $urandom_range(0, 63) == 0;
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
